// File: rtl/memory_stack_pkg.sv
// Shared definitions for the SAP-2 memory/return-stack block: FSM states and
// the byte addresses of a stack entry inside RAM.
package memory_stack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUSH_H = 3'd1,
        ST_PUSH_L = 3'd2,
        ST_POP_H  = 3'd3,
        ST_POP_L  = 3'd4
    } state_e;

    // Entry k grows downward from the top of RAM: high byte first, low byte after it.
    function automatic int stk_hi(input int ram_bytes, input int k);
        return ram_bytes - 2 - 2 * k;
    endfunction

    function automatic int stk_lo(input int ram_bytes, input int k);
        return ram_bytes - 1 - 2 * k;
    endfunction

endpackage

// File: rtl/memory_stack_ram_sp.sv
// Byte-wide single-port RAM. The read is combinational so that the MDR in the
// top level acts as the registered read stage of every access.
module memory_stack_ram_sp #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stack.sv
// SAP-2 memory: MAR, 16-bit MDR, byte RAM and a multi-level return stack held
// in the top 2*STK_DEPTH bytes of RAM, moved one byte per cycle by a small FSM.
module memory_stack
    import memory_stack_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int STK_DEPTH = 8,
    parameter int SP_W      = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mar_loadh_i,
    input  logic            mar_loadl_i,
    input  logic            mdr_loadh_i,
    input  logic            mdr_load_i,
    input  logic            ram_load_i,
    input  logic            ram_enh_i,
    input  logic            ram_enl_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            clr_flags_i,
    input  logic [15:0]     bus_i,
    output logic [15:0]     out_o,
    output logic            busy_o,
    output logic [SP_W-1:0] sp_o,
    output logic            stk_ovf_o,
    output logic            stk_unf_o
);

    localparam int RAM_BYTES = 2**ADDR_W;

    state_e            state_q;
    logic [15:0]       mar_q;
    logic [15:0]       mdr_q;
    logic [15:0]       ra_q;
    logic [SP_W-1:0]   sp_q;
    logic              busy_q;
    logic              ovf_q;
    logic              unf_q;

    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] push_hi_addr;
    logic [ADDR_W-1:0] push_lo_addr;
    logic [ADDR_W-1:0] pop_hi_addr;
    logic [ADDR_W-1:0] pop_lo_addr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic              stk_full;
    logic              stk_empty;
    logic              unused_mar_hi;

    // Only the low MAR bits reach the RAM; the rest is architectural state.
    assign unused_mar_hi = ^mar_q[15:ADDR_W];

    assign sp_dec       = sp_q - SP_W'(1);
    assign push_hi_addr = ADDR_W'(stk_hi(RAM_BYTES, int'(sp_q)));
    assign push_lo_addr = ADDR_W'(stk_lo(RAM_BYTES, int'(sp_q)));
    assign pop_hi_addr  = ADDR_W'(stk_hi(RAM_BYTES, int'(sp_dec)));
    assign pop_lo_addr  = ADDR_W'(stk_lo(RAM_BYTES, int'(sp_dec)));

    assign stk_full  = (sp_q == SP_W'(STK_DEPTH));
    assign stk_empty = (sp_q == '0);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = mar_q[ADDR_W-1:0];
        ram_wdata = mdr_q[7:0];
        case (state_q)
            ST_IDLE: begin
                ram_we = ram_load_i & ~ret_i & ~call_i & ~ram_enh_i & ~ram_enl_i;
            end
            ST_PUSH_H: begin
                ram_we    = 1'b1;
                ram_addr  = push_hi_addr;
                ram_wdata = ra_q[15:8];
            end
            ST_PUSH_L: begin
                ram_we    = 1'b1;
                ram_addr  = push_lo_addr;
                ram_wdata = ra_q[7:0];
            end
            ST_POP_H: ram_addr = pop_hi_addr;
            ST_POP_L: ram_addr = pop_lo_addr;
            default:  ram_we = 1'b0;
        endcase
    end

    memory_stack_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            ra_q    <= '0;
            sp_q    <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (mar_loadh_i) mar_q[15:8] <= bus_i[15:8];
            if (mar_loadl_i) mar_q[7:0]  <= bus_i[7:0];

            // Flag sets below are later in the block, so a set beats a clear.
            if (clr_flags_i) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (mdr_loadh_i) mdr_q[15:8] <= bus_i[15:8];
                    if (mdr_load_i)  mdr_q[7:0]  <= bus_i[7:0];
                    if (ret_i) begin
                        if (stk_empty) begin
                            unf_q <= 1'b1;
                        end else begin
                            state_q <= ST_POP_H;
                            busy_q  <= 1'b1;
                        end
                    end else if (call_i) begin
                        if (stk_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            ra_q    <= bus_i;
                            state_q <= ST_PUSH_H;
                            busy_q  <= 1'b1;
                        end
                    end else if (ram_enh_i) begin
                        mdr_q[15:8] <= ram_rdata;
                    end else if (ram_enl_i) begin
                        mdr_q[7:0] <= ram_rdata;
                    end
                end
                ST_PUSH_H: state_q <= ST_PUSH_L;
                ST_PUSH_L: begin
                    sp_q    <= sp_q + SP_W'(1);
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_POP_H: begin
                    mdr_q[15:8] <= ram_rdata;
                    state_q     <= ST_POP_L;
                end
                ST_POP_L: begin
                    mdr_q[7:0] <= ram_rdata;
                    sp_q       <= sp_dec;
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o     = mdr_q;
    assign busy_o    = busy_q;
    assign sp_o      = sp_q;
    assign stk_ovf_o = ovf_q;
    assign stk_unf_o = unf_q;

endmodule

// File: tb/tb_memory_stack.sv
// Directed bench for memory_stack: RAM path, push/pop stack, flags and busy.
module tb_memory_stack;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mar_loadh_i, mar_loadl_i, mdr_loadh_i, mdr_load_i;
    logic        ram_load_i, ram_enh_i, ram_enl_i, call_i, ret_i, clr_flags_i;
    logic [15:0] bus_i;
    logic [15:0] out_o;
    logic        busy_o;
    logic [3:0]  sp_o;
    logic        stk_ovf_o, stk_unf_o;

    int checks = 0;
    int failures = 0;

    memory_stack #(
        .ADDR_W    (6),
        .STK_DEPTH (8),
        .SP_W      (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mar_loadh_i (mar_loadh_i),
        .mar_loadl_i (mar_loadl_i),
        .mdr_loadh_i (mdr_loadh_i),
        .mdr_load_i  (mdr_load_i),
        .ram_load_i  (ram_load_i),
        .ram_enh_i   (ram_enh_i),
        .ram_enl_i   (ram_enl_i),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .clr_flags_i (clr_flags_i),
        .bus_i       (bus_i),
        .out_o       (out_o),
        .busy_o      (busy_o),
        .sp_o        (sp_o),
        .stk_ovf_o   (stk_ovf_o),
        .stk_unf_o   (stk_unf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_inputs();
        mar_loadh_i = 0; mar_loadl_i = 0; mdr_loadh_i = 0; mdr_load_i = 0;
        ram_load_i = 0; ram_enh_i = 0; ram_enl_i = 0;
        call_i = 0; ret_i = 0; clr_flags_i = 0; bus_i = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] a);
        bus_i = a; mar_loadh_i = 1; mar_loadl_i = 1;
        step();
        clear_inputs();
    endtask

    task automatic set_mdr(input logic [15:0] d);
        bus_i = d; mdr_loadh_i = 1; mdr_load_i = 1;
        step();
        clear_inputs();
    endtask

    task automatic ram_write(input logic [15:0] a, input logic [7:0] d);
        set_mar(a);
        set_mdr({8'h00, d});
        ram_load_i = 1;
        step();
        clear_inputs();
        $display("write RAM[%0d]=%02h", a, d);
    endtask

    task automatic ram_read(input logic [15:0] a, output logic [7:0] d);
        set_mar(a);
        ram_enl_i = 1;
        step();
        clear_inputs();
        d = out_o[7:0];
        $display("read  RAM[%0d]=%02h", a, d);
    endtask

    // Counts cycles with busy high; bounded so a stuck FSM cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o !== 1'b0 && n < 10) begin
            n++;
            step();
        end
    endtask

    task automatic do_call(input logic [15:0] v, output int n);
        bus_i = v; call_i = 1;
        step();
        clear_inputs();
        wait_idle(n);
        $display("call  %04h busy_cycles=%0d sp=%0d", v, n, sp_o);
    endtask

    task automatic do_ret(output int n);
        ret_i = 1;
        step();
        clear_inputs();
        wait_idle(n);
        $display("ret   out=%04h busy_cycles=%0d sp=%0d", out_o, n, sp_o);
    endtask

    task automatic test_reset();
        ret_i = 1;
        step();
        clear_inputs();
        checks++; if (stk_unf_o !== 1'b1) begin failures++; $display("FAIL pre_reset_unf got=%b exp=1", stk_unf_o); end
        set_mdr(16'hFFFF);
        bus_i = 16'h5555; call_i = 1;
        step();
        clear_inputs();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy_o); end
        #2 rst_ni = 0;
        #1;
        checks++; if (out_o !== 16'h0000) begin failures++; $display("FAIL async_reset_out got=%04h exp=0000", out_o); end
        step();
        rst_ni = 1;
        step();
        $display("reset released out=%04h sp=%0d busy=%b", out_o, sp_o, busy_o);
        checks++; if (out_o !== 16'h0000) begin failures++; $display("FAIL reset_out got=%04h exp=0000", out_o); end
        checks++; if (sp_o !== 4'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", sp_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (stk_ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", stk_ovf_o); end
        checks++; if (stk_unf_o !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", stk_unf_o); end
    endtask

    task automatic test_ram_path();
        ram_write(16'h0005, 8'hA7);
        set_mdr(16'h0000);
        ram_enl_i = 1;
        step();
        clear_inputs();
        checks++; if (out_o !== 16'h00A7) begin failures++; $display("FAIL ram_enl got=%04h exp=00A7", out_o); end
        ram_enh_i = 1;
        step();
        clear_inputs();
        checks++; if (out_o !== 16'hA7A7) begin failures++; $display("FAIL ram_enh got=%04h exp=A7A7", out_o); end
        bus_i = 16'h2211; mdr_loadh_i = 1; mdr_load_i = 1; ram_enl_i = 1;
        step();
        clear_inputs();
        $display("read+bus load out=%04h", out_o);
        checks++; if (out_o !== 16'h22A7) begin failures++; $display("FAIL read_beats_bus got=%04h exp=22A7", out_o); end
    endtask

    task automatic test_push();
        int n;
        logic [7:0] d;
        do_call(16'h1234, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL call1_busy got=%0d exp=2", n); end
        checks++; if (sp_o !== 4'd1) begin failures++; $display("FAIL call1_sp got=%0d exp=1", sp_o); end
        do_call(16'hBEEF, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL call2_busy got=%0d exp=2", n); end
        checks++; if (sp_o !== 4'd2) begin failures++; $display("FAIL call2_sp got=%0d exp=2", sp_o); end
        ram_read(16'd62, d);
        checks++; if (d !== 8'h12) begin failures++; $display("FAIL ram62 got=%02h exp=12", d); end
        ram_read(16'd63, d);
        checks++; if (d !== 8'h34) begin failures++; $display("FAIL ram63 got=%02h exp=34", d); end
        ram_read(16'd60, d);
        checks++; if (d !== 8'hBE) begin failures++; $display("FAIL ram60 got=%02h exp=BE", d); end
        ram_read(16'd61, d);
        checks++; if (d !== 8'hEF) begin failures++; $display("FAIL ram61 got=%02h exp=EF", d); end
    endtask

    task automatic test_pop();
        int n;
        do_ret(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL ret1_busy got=%0d exp=2", n); end
        checks++; if (out_o !== 16'hBEEF) begin failures++; $display("FAIL ret1_out got=%04h exp=BEEF", out_o); end
        checks++; if (sp_o !== 4'd1) begin failures++; $display("FAIL ret1_sp got=%0d exp=1", sp_o); end
        do_ret(n);
        checks++; if (out_o !== 16'h1234) begin failures++; $display("FAIL ret2_out got=%04h exp=1234", out_o); end
        checks++; if (sp_o !== 4'd0) begin failures++; $display("FAIL ret2_sp got=%0d exp=0", sp_o); end
        // Underflow together with clr_flags: the set must win.
        ret_i = 1; clr_flags_i = 1;
        step();
        clear_inputs();
        $display("ret on empty unf=%b busy=%b out=%04h", stk_unf_o, busy_o, out_o);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL unf_busy got=%b exp=0", busy_o); end
        checks++; if (stk_unf_o !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", stk_unf_o); end
        checks++; if (out_o !== 16'h1234) begin failures++; $display("FAIL unf_out got=%04h exp=1234", out_o); end
        checks++; if (sp_o !== 4'd0) begin failures++; $display("FAIL unf_sp got=%0d exp=0", sp_o); end
        step();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL unf_busy_later got=%b exp=0", busy_o); end
        checks++; if (stk_unf_o !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", stk_unf_o); end
        clr_flags_i = 1;
        step();
        clear_inputs();
        checks++; if (stk_unf_o !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", stk_unf_o); end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] d;
        logic [7:0] exp_b;
        for (int i = 0; i < 8; i++) begin
            do_call(16'h0100 + 16'(i), n);
            checks++; if (n !== 2) begin failures++; $display("FAIL fill_busy[%0d] got=%0d exp=2", i, n); end
        end
        checks++; if (sp_o !== 4'd8) begin failures++; $display("FAIL full_sp got=%0d exp=8", sp_o); end
        bus_i = 16'h0999; call_i = 1;
        step();
        clear_inputs();
        $display("call on full ovf=%b busy=%b sp=%0d", stk_ovf_o, busy_o, sp_o);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ovf_busy got=%b exp=0", busy_o); end
        checks++; if (stk_ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", stk_ovf_o); end
        checks++; if (sp_o !== 4'd8) begin failures++; $display("FAIL ovf_sp got=%0d exp=8", sp_o); end
        for (int a = 48; a < 64; a++) begin
            exp_b = (a % 2 == 1) ? 8'((63 - a) / 2) : 8'h01;
            ram_read(16'(a), d);
            checks++; if (d !== exp_b) begin failures++; $display("FAIL stack_ram[%0d] got=%02h exp=%02h", a, d, exp_b); end
        end
        for (int i = 0; i < 8; i++) begin
            do_ret(n);
            checks++; if (out_o !== 16'h0107 - 16'(i)) begin failures++; $display("FAIL drain[%0d] got=%04h exp=%04h", i, out_o, 16'h0107 - 16'(i)); end
        end
        checks++; if (sp_o !== 4'd0) begin failures++; $display("FAIL drain_sp got=%0d exp=0", sp_o); end
        clr_flags_i = 1;
        step();
        clear_inputs();
        checks++; if (stk_ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", stk_ovf_o); end
    endtask

    task automatic test_busy_and_priority();
        int n;
        ram_write(16'h0033, 8'hC3);
        set_mdr(16'h0000);
        set_mar(16'h0000);
        bus_i = 16'hABCD; call_i = 1;
        step();
        clear_inputs();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_push got=%b exp=1", busy_o); end
        bus_i = 16'h0033; ram_enl_i = 1; mdr_load_i = 1; mdr_loadh_i = 1; mar_loadl_i = 1;
        step();
        clear_inputs();
        wait_idle(n);
        $display("busy-time requests out=%04h sp=%0d", out_o, sp_o);
        checks++; if (n !== 1) begin failures++; $display("FAIL busy_remaining got=%0d exp=1", n); end
        checks++; if (out_o !== 16'h0000) begin failures++; $display("FAIL mdr_held got=%04h exp=0000", out_o); end
        checks++; if (sp_o !== 4'd1) begin failures++; $display("FAIL busy_sp got=%0d exp=1", sp_o); end
        ram_enl_i = 1;
        step();
        clear_inputs();
        checks++; if (out_o !== 16'h00C3) begin failures++; $display("FAIL mar_during_busy got=%04h exp=00C3", out_o); end
        bus_i = 16'h7777; call_i = 1; ret_i = 1;
        step();
        clear_inputs();
        wait_idle(n);
        $display("call+ret out=%04h sp=%0d", out_o, sp_o);
        checks++; if (n !== 2) begin failures++; $display("FAIL callret_busy got=%0d exp=2", n); end
        checks++; if (out_o !== 16'hABCD) begin failures++; $display("FAIL callret_out got=%04h exp=ABCD", out_o); end
        checks++; if (sp_o !== 4'd0) begin failures++; $display("FAIL callret_sp got=%0d exp=0", sp_o); end
        checks++; if (stk_ovf_o !== 1'b0) begin failures++; $display("FAIL callret_ovf got=%b exp=0", stk_ovf_o); end
    endtask

    initial begin
        clear_inputs();
        rst_ni = 0;
        step();
        step();
        rst_ni = 1;
        step();
        test_reset();
        test_ram_path();
        test_push();
        test_pop();
        test_overflow();
        test_busy_and_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
